// File: rtl/uart_word_loader.sv
// uart_word_loader: host boot protocol front end between the UART and the
// instruction memory / data receive buffer.
//   sync byte -> ACK, 32-bit little-endian length header N, N instruction
//   words, then ACK and program_loaded; later words go out as data words.
// Optional feature macro: UART_WORD_LOADER_CHECKSUM_EN
//   Adds a checksum word after the instructions (CHK state). A mismatch
//   answers NACK and parks the loader in HALT until reset.
module uart_word_loader #(
  parameter logic [7:0] SYNC_BYTE = 8'h99,
`ifdef UART_WORD_LOADER_CHECKSUM_EN
  parameter logic [7:0] NACK_BYTE = 8'hEE,
`endif
  parameter logic [7:0] ACK_BYTE  = 8'hAA
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx_ready,
  input  logic [7:0]  rdata,
  input  logic        ferr,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [7:0]  sdata,
  output logic        instr_ready,
  output logic        data_ready,
  output logic [31:0] content,
  output logic        program_loaded
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LEN   = 3'd1;
  localparam logic [2:0] ST_INSTR = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
`ifdef UART_WORD_LOADER_CHECKSUM_EN
  localparam logic [2:0] ST_CHK   = 3'd4;
  localparam logic [2:0] ST_HALT  = 3'd5;
`endif

  logic [2:0]  state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [23:0] word_q, word_d;
  logic [31:0] content_q, content_d;
  logic        instr_ready_q, instr_ready_d;
  logic        data_ready_q, data_ready_d;
  logic [31:0] count_q, count_d;
  logic [31:0] rcvd_q, rcvd_d;
  logic        loaded_q, loaded_d;
  logic        pending_q, pending_d;
  logic [7:0]  pend_byte_q, pend_byte_d;
  logic        tx_start_q, tx_start_d;
  logic [7:0]  sdata_q, sdata_d;
`ifdef UART_WORD_LOADER_CHECKSUM_EN
  logic [31:0] sum_q, sum_d;
`endif

  logic        accept_s;
  logic        collecting_s;
  logic        word_done_s;
  logic [31:0] full_word_s;
  logic        queue_s;
  logic [7:0]  queue_byte_s;

  assign accept_s    = rx_ready && !ferr;
  assign full_word_s = {rdata, word_q};

  // Next-state logic: byte collection, protocol FSM and the one-entry tx queue
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    word_d        = word_q;
    content_d     = content_q;
    instr_ready_d = 1'b0;
    data_ready_d  = 1'b0;
    count_d       = count_q;
    rcvd_d        = rcvd_q;
    loaded_d      = loaded_q;
    pending_d     = pending_q;
    pend_byte_d   = pend_byte_q;
    tx_start_d    = 1'b0;
    sdata_d       = sdata_q;
`ifdef UART_WORD_LOADER_CHECKSUM_EN
    sum_d         = sum_q;
`endif
    queue_s       = 1'b0;
    queue_byte_s  = 8'h00;

    // Bytes are only assembled once a session has been opened by a sync.
    case (state_q)
      ST_LEN, ST_INSTR, ST_DONE: collecting_s = 1'b1;
`ifdef UART_WORD_LOADER_CHECKSUM_EN
      ST_CHK:                    collecting_s = 1'b1;
`endif
      default:                   collecting_s = 1'b0;
    endcase
    word_done_s = accept_s && collecting_s && (idx_q == 2'd3);

    if (accept_s && collecting_s) begin
      case (idx_q)
        2'd0:    begin word_d[7:0]   = rdata; idx_d = 2'd1; end
        2'd1:    begin word_d[15:8]  = rdata; idx_d = 2'd2; end
        2'd2:    begin word_d[23:16] = rdata; idx_d = 2'd3; end
        default: begin idx_d = 2'd0; end
      endcase
    end else begin
      idx_d = idx_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept_s && (rdata == SYNC_BYTE)) begin
          queue_s      = 1'b1;
          queue_byte_s = ACK_BYTE;
          state_d      = ST_LEN;
          idx_d        = 2'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LEN: begin
        if (word_done_s) begin
          count_d = full_word_s;
          rcvd_d  = 32'd0;
`ifdef UART_WORD_LOADER_CHECKSUM_EN
          sum_d   = 32'd0;
          if (full_word_s == 32'd0) begin
            state_d = ST_CHK;
          end else begin
            state_d = ST_INSTR;
          end
`else
          if (full_word_s == 32'd0) begin
            state_d      = ST_DONE;
            loaded_d     = 1'b1;
            queue_s      = 1'b1;
            queue_byte_s = ACK_BYTE;
          end else begin
            state_d = ST_INSTR;
          end
`endif
        end else begin
          state_d = ST_LEN;
        end
      end
      ST_INSTR: begin
        if (word_done_s) begin
          instr_ready_d = 1'b1;
          content_d     = full_word_s;
          rcvd_d        = rcvd_q + 32'd1;
`ifdef UART_WORD_LOADER_CHECKSUM_EN
          sum_d         = sum_q + full_word_s;
          if ((rcvd_q + 32'd1) == count_q) begin
            state_d = ST_CHK;
          end else begin
            state_d = ST_INSTR;
          end
`else
          if ((rcvd_q + 32'd1) == count_q) begin
            state_d      = ST_DONE;
            loaded_d     = 1'b1;
            queue_s      = 1'b1;
            queue_byte_s = ACK_BYTE;
          end else begin
            state_d = ST_INSTR;
          end
`endif
        end else begin
          state_d = ST_INSTR;
        end
      end
`ifdef UART_WORD_LOADER_CHECKSUM_EN
      ST_CHK: begin
        if (word_done_s) begin
          queue_s = 1'b1;
          if (full_word_s == sum_q) begin
            state_d      = ST_DONE;
            loaded_d     = 1'b1;
            queue_byte_s = ACK_BYTE;
          end else begin
            state_d      = ST_HALT;
            queue_byte_s = NACK_BYTE;
          end
        end else begin
          state_d = ST_CHK;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
`endif
      ST_DONE: begin
        // A sync byte here is just payload.
        if (word_done_s) begin
          data_ready_d = 1'b1;
          content_d    = full_word_s;
        end else begin
          data_ready_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = 2'd0;
      end
    endcase

    // Launch the pending byte; the tx_start_q term keeps launches at least
    // one cycle apart so the transmitter can raise busy.
    if (pending_q && !tx_busy && !tx_start_q) begin
      tx_start_d = 1'b1;
      sdata_d    = pend_byte_q;
      pending_d  = 1'b0;
    end else begin
      tx_start_d = 1'b0;
    end

    // A newly queued byte overwrites any byte still waiting.
    if (queue_s) begin
      pending_d   = 1'b1;
      pend_byte_d = queue_byte_s;
    end else begin
      pend_byte_d = pend_byte_d;
    end
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      idx_q         <= 2'd0;
      word_q        <= 24'h000000;
      content_q     <= 32'h00000000;
      instr_ready_q <= 1'b0;
      data_ready_q  <= 1'b0;
      count_q       <= 32'd0;
      rcvd_q        <= 32'd0;
      loaded_q      <= 1'b0;
      pending_q     <= 1'b0;
      pend_byte_q   <= 8'h00;
      tx_start_q    <= 1'b0;
      sdata_q       <= 8'h00;
`ifdef UART_WORD_LOADER_CHECKSUM_EN
      sum_q         <= 32'd0;
`endif
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      word_q        <= word_d;
      content_q     <= content_d;
      instr_ready_q <= instr_ready_d;
      data_ready_q  <= data_ready_d;
      count_q       <= count_d;
      rcvd_q        <= rcvd_d;
      loaded_q      <= loaded_d;
      pending_q     <= pending_d;
      pend_byte_q   <= pend_byte_d;
      tx_start_q    <= tx_start_d;
      sdata_q       <= sdata_d;
`ifdef UART_WORD_LOADER_CHECKSUM_EN
      sum_q         <= sum_d;
`endif
    end
  end

  assign tx_start       = tx_start_q;
  assign sdata          = sdata_q;
  assign instr_ready    = instr_ready_q;
  assign data_ready     = data_ready_q;
  assign content        = content_q;
  assign program_loaded = loaded_q;

endmodule

// File: tb/tb_uart_word_loader.sv
// Directed bench for uart_word_loader: sync handshake, instruction load,
// data words, framing errors, tx back-pressure and reset behaviour.
// With UART_WORD_LOADER_CHECKSUM_EN defined it also drives the checksum cases.
module tb_uart_word_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        rx_ready = 1'b0;
  logic [7:0]  rdata = 8'h00;
  logic        ferr = 1'b0;
  logic        tx_busy = 1'b0;
  logic        tx_start;
  logic [7:0]  sdata;
  logic        instr_ready;
  logic        data_ready;
  logic [31:0] content;
  logic        program_loaded;

  int n_checks = 0;
  int n_errors = 0;
  int both_hi  = 0;
  int tx_back  = 0;

  logic [31:0] instr_log[$];
  logic [31:0] data_log[$];
  logic [7:0]  tx_log[$];
  logic        tx_prev = 1'b0;

  uart_word_loader dut (
    .clock          (clock),
    .reset          (reset),
    .rx_ready       (rx_ready),
    .rdata          (rdata),
    .ferr           (ferr),
    .tx_busy        (tx_busy),
    .tx_start       (tx_start),
    .sdata          (sdata),
    .instr_ready    (instr_ready),
    .data_ready     (data_ready),
    .content        (content),
    .program_loaded (program_loaded)
  );

  // 100 MHz clock
  always #5 clock = ~clock;

  // Record output pulses on the falling edge, away from the active edge
  always @(negedge clock) begin
    if (!reset) begin
      if (instr_ready) instr_log.push_back(content);
      if (data_ready)  data_log.push_back(content);
      if (tx_start)    tx_log.push_back(sdata);
      if (instr_ready && data_ready) both_hi++;
      if (tx_start && tx_prev) tx_back++;
      tx_prev = tx_start;
    end else begin
      tx_prev = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic fe);
    @(negedge clock);
    rx_ready = 1'b1;
    rdata    = b;
    ferr     = fe;
    @(negedge clock);
    rx_ready = 1'b0;
    ferr     = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    logic [31:0] t;
    t = w;
    for (int i = 0; i < 4; i++) begin
      send_byte(t[7:0], 1'b0);
      t = t >> 8;
    end
  endtask

  task automatic clear_logs();
    instr_log.delete();
    data_log.delete();
    tx_log.delete();
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    wait_cycles(2);
    reset = 1'b0;
    clear_logs();
  endtask

  initial begin
    // Reset state
    wait_cycles(3);
    check("rst_tx_start", {31'd0, tx_start}, 32'd0);
    check("rst_sdata", {24'd0, sdata}, 32'd0);
    check("rst_instr_ready", {31'd0, instr_ready}, 32'd0);
    check("rst_data_ready", {31'd0, data_ready}, 32'd0);
    check("rst_content", content, 32'd0);
    check("rst_loaded", {31'd0, program_loaded}, 32'd0);
    reset = 1'b0;
    wait_cycles(2);

    // Non-sync byte in IDLE is ignored; sync answers ACK
    send_byte(8'h12, 1'b0);
    wait_cycles(5);
    check("idle_ignore_tx", tx_log.size(), 32'd0);
    send_byte(8'h99, 1'b0);
    check("sync_tx_not_yet", {31'd0, tx_start}, 32'd0);
    @(negedge clock);
    check("sync_tx_lat", {31'd0, tx_start}, 32'd1);
    check("sync_tx_byte", {24'd0, sdata}, 32'h000000AA);
    wait_cycles(5);
    check("sync_tx_count", tx_log.size(), 32'd1);
    check("sdata_stable", {24'd0, sdata}, 32'h000000AA);
    clear_logs();

    // Header N=2, then two instruction words; a framing-error byte mid-word
    send_word(32'd2);
    check("len_no_instr", {31'd0, instr_ready}, 32'd0);
    send_byte(8'h78, 1'b0);
    send_byte(8'h56, 1'b0);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h34, 1'b0);
    send_byte(8'h12, 1'b0);
    check("w0_pulse", {31'd0, instr_ready}, 32'd1);
    check("w0_content", content, 32'h12345678);
    check("w0_not_loaded", {31'd0, program_loaded}, 32'd0);
    send_word(32'hDEADBEEF);
    check("w1_pulse", {31'd0, instr_ready}, 32'd1);
    check("w1_loaded", {31'd0, program_loaded}, 32'd1);
    wait_cycles(6);
    check("instr_count", instr_log.size(), 32'd2);
    if (instr_log.size() == 2) begin
      check("instr0", instr_log[0], 32'h12345678);
      check("instr1", instr_log[1], 32'hDEADBEEF);
    end
    check("content_hold", content, 32'hDEADBEEF);
    check("done_ack_count", tx_log.size(), 32'd1);
    if (tx_log.size() == 1) check("done_ack_byte", {24'd0, tx_log[0]}, 32'h000000AA);
    check("no_data_yet", data_log.size(), 32'd0);

    // DONE: words become data words; sync byte is plain payload
    send_word(32'h00000001);
    check("d0_pulse", {31'd0, data_ready}, 32'd1);
    check("d0_content", content, 32'h00000001);
    send_word(32'h00000099);
    wait_cycles(4);
    check("data_count", data_log.size(), 32'd2);
    if (data_log.size() == 2) check("data1", data_log[1], 32'h00000099);
    check("done_sync_no_tx", tx_log.size(), 32'd1);
    check("done_instr_count", instr_log.size(), 32'd2);

    // Reset mid-word clears outputs and returns to IDLE
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("mid_rst_loaded", {31'd0, program_loaded}, 32'd0);
    check("mid_rst_content", content, 32'd0);
    check("mid_rst_data_ready", {31'd0, data_ready}, 32'd0);
    reset = 1'b0;
    clear_logs();
    send_word(32'h00000001);
    wait_cycles(4);
    check("idle_after_rst_data", data_log.size(), 32'd0);
    check("idle_after_rst_instr", instr_log.size(), 32'd0);
    check("idle_after_rst_tx", tx_log.size(), 32'd0);

    // ACK held off by tx_busy, then N=0 goes straight to DONE
    tx_busy = 1'b1;
    send_byte(8'h99, 1'b0);
    wait_cycles(50);
    check("busy_hold", tx_log.size(), 32'd0);
    tx_busy = 1'b0;
    wait_cycles(6);
    check("busy_release_count", tx_log.size(), 32'd1);
    send_word(32'd0);
    check("n0_loaded", {31'd0, program_loaded}, 32'd1);
    wait_cycles(6);
    check("n0_ack_count", tx_log.size(), 32'd2);
    if (tx_log.size() == 2) check("n0_ack_byte", {24'd0, tx_log[1]}, 32'h000000AA);
    check("n0_no_instr", instr_log.size(), 32'd0);
    send_word(32'h00000001);
    check("n0_data_pulse", {31'd0, data_ready}, 32'd1);
    check("n0_data_content", content, 32'h00000001);

`ifdef UART_WORD_LOADER_CHECKSUM_EN
    // Bad checksum: NACK, HALT ignores everything
    do_reset();
    send_byte(8'h99, 1'b0);
    send_word(32'd1);
    send_word(32'd5);
    send_word(32'd6);
    wait_cycles(6);
    check("cks_bad_tx_count", tx_log.size(), 32'd2);
    if (tx_log.size() == 2) check("cks_bad_nack", {24'd0, tx_log[1]}, 32'h000000EE);
    check("cks_bad_loaded", {31'd0, program_loaded}, 32'd0);
    send_byte(8'h99, 1'b0);
    send_word(32'h00000007);
    wait_cycles(6);
    check("halt_tx", tx_log.size(), 32'd2);
    check("halt_data", data_log.size(), 32'd0);
    check("halt_loaded", {31'd0, program_loaded}, 32'd0);

    // Good checksum: ACK and program_loaded
    do_reset();
    send_byte(8'h99, 1'b0);
    send_word(32'd1);
    send_word(32'd5);
    check("cks_not_loaded_yet", {31'd0, program_loaded}, 32'd0);
    send_word(32'd5);
    wait_cycles(6);
    check("cks_ok_loaded", {31'd0, program_loaded}, 32'd1);
    check("cks_ok_tx_count", tx_log.size(), 32'd2);
    if (tx_log.size() == 2) check("cks_ok_ack", {24'd0, tx_log[1]}, 32'h000000AA);
`endif

    check("pulse_exclusive", both_hi, 32'd0);
    check("tx_no_back_to_back", tx_back, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Watchdog: the run must end on its own
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/uart_word_loader.md
Name: uart_word_loader

Overview:
- Sits between the UART receiver/transmitter and the instruction memory / receive ring buffer on the board top.
- Handles the host boot protocol: sync handshake, instruction-count header, then instruction words.
- Assembles received bytes into 32-bit little-endian words.
- Before program load, each word is pushed to instruction memory. After load, each word is pushed to the data receive buffer. program_loaded releases the core from reset.

Parameters:
- SYNC_BYTE, 8'h99, byte the host sends to start a boot session
- ACK_BYTE, 8'hAA, byte returned on sync accept and on load completion
- NACK_BYTE, 8'hEE, byte returned on checksum failure (optional feature only)

Ports:
- clock  in  1  system clock (cpu clock domain)
- reset  in  1  asynchronous, active-high reset
- rx_ready  in  1  one-cycle pulse: rdata holds a received byte
- rdata  in  8  received byte
- ferr  in  1  framing error flag, qualified by rx_ready
- tx_busy  in  1  UART transmitter busy
- tx_start  out  1  one-cycle pulse: start sending sdata
- sdata  out  8  byte to send
- instr_ready  out  1  one-cycle pulse: content is an instruction word
- data_ready  out  1  one-cycle pulse: content is a data word
- content  out  32  assembled word
- program_loaded  out  1  level, high once all instructions are received

Behaviour:
- Reset (async, active-high): all outputs 0; state=IDLE; byte index=0; word count=0; tx pending=0.
- Byte acceptance: a byte is accepted on a rx_ready cycle with ferr=0. A byte with ferr=1 is dropped and the byte index does not advance.
- Word assembly: the k-th accepted byte (k=0..3) goes to bits [8k+7:8k].
- On the 4th byte, the next cycle carries a one-cycle pulse with content valid. content holds its value until the next word completes.
- IDLE: accepted bytes other than SYNC_BYTE are ignored. On SYNC_BYTE: queue ACK_BYTE, go to LEN with index=0.
- LEN: assemble one word into count N.
  - N=0: go to DONE.
  - Otherwise: go to INSTR.
- INSTR: every completed word pulses instr_ready. After the N-th word, go to DONE (or CHK if the optional feature is enabled).
- DONE: on entry, set program_loaded=1 (held until reset) and queue ACK_BYTE. Every later completed word pulses data_ready. A SYNC_BYTE here is treated as ordinary data.
- instr_ready and data_ready are never high in the same cycle, and at most one pulses per cycle.
- Transmit queue: one-entry pending register.
  - tx_start pulses for one cycle when pending=1, tx_busy=0 and tx_start was 0 in the previous cycle; pending clears in that cycle.
  - sdata is registered and stable from the tx_start cycle onward.
  - If a second byte is queued while pending=1, it overwrites the first. The protocol guarantees this cannot happen with a compliant host.
- Latency:
  - rx_ready of the 4th byte → word pulse: 1 cycle.
  - sync byte → tx_start: at least 2 cycles, stretched while tx_busy=1.
- Boundaries:
  - The word counter is 32 bits; compare with the number of words received so far, no wrap handling (N < 2^32).
  - Reset mid-word discards partial bytes.
  - Reset mid-load clears program_loaded.

Optional Feature:
- Macro: UART_WORD_LOADER_CHECKSUM_EN
- With the macro:
  - After the N instruction words, state CHK receives one more word C.
  - S = 32-bit wrapping sum of all instruction words.
  - C==S: go to DONE as normal.
  - C!=S: queue NACK_BYTE, go to HALT. HALT ignores all input and keeps program_loaded=0 until reset.
  - N=0 still passes through CHK with expected C=0.
- Without the macro: no CHK or HALT state, no sum register; INSTR goes directly to DONE.

Test Plan:
- Bytes 0x12, 0x99 → no output for 0x12. tx_start pulses once with sdata=0xAA after 0x99, with tx_busy=0.
- Sync, then N=2 (00 00 00 02 on the wire as 02 00 00 00), then 78 56 34 12, EF BE AD DE → instr_ready pulses carrying 0x12345678 then 0xDEADBEEF. program_loaded rises after the second word; second 0xAA sent.
- Sync, then N=0 → program_loaded=1 immediately after the 4th header byte, ACK sent, no instr_ready. Then bytes 01 00 00 00 → data_ready with content 0x00000001.
- During INSTR, a byte with ferr=1 inserted mid-word → byte dropped; the word assembles correctly from the next valid byte.
- ACK queued while tx_busy=1 for 50 cycles → tx_start held off, then pulses exactly once after tx_busy falls. Reset asserted mid-word → all outputs 0, state IDLE.
- CHECKSUM_EN: N=1, word 0x00000005, C=0x00000006 → sdata 0xEE, program_loaded stays 0, later bytes ignored. With C=0x00000005 → ACK sent, program_loaded=1.
